// File: rtl/qnigma_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, held for the whole transaction, with a rotating priority pointer.
// Optional watchdog release is compiled in with the QNIGMA_ARB_TIMEOUT_EN macro.
module qnigma_rr_arbiter #(
    parameter int N     = 4,
    parameter int TMO   = 1024,
    parameter int TMO_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic                   done,
    output logic [N-1:0]           gnt,
    output logic                   gnt_vld,
    output logic [$clog2(N)-1:0]   gnt_idx,
    output logic                   tmo
);

    localparam int IW = $clog2(N);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    if ((N < 2) || (N > 32) || (TMO < 2) || (TMO_W < 1) ||
        (64'(TMO) >= (64'd1 << TMO_W))) begin : g_bad_param
        $error("qnigma_rr_arbiter: illegal parameter set");
    end

    // Isolate the lowest set bit: two's complement trick keeps only that bit.
    function automatic logic [N-1:0] lsb_onehot(input logic [N-1:0] v);
        return v & (~v + {{(N-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            idx = idx | (oh[k] ? IW'(k) : {IW{1'b0}});
        end
        return idx;
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic [N-1:0]    gnt_r;
    logic [N-1:0]    gnt_nxt_s;
    logic            gnt_vld_r;
    logic [IW-1:0]   gnt_idx_r;
    logic [IW-1:0]   idx_nxt_s;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   ptr_nxt_s;
    logic [N-1:0]    above_s;
    logic [N-1:0]    masked_s;
    logic [N-1:0]    cand_s;
    logic [N-1:0]    win_oh_s;
    logic [IW-1:0]   win_idx_s;
    logic            release_s;

`ifdef QNIGMA_ARB_TIMEOUT_EN
    logic [TMO_W-1:0] cnt_r;
    logic [TMO_W-1:0] cnt_nxt_s;
    logic             tmo_r;
    logic             tmo_nxt_s;
    logic             expire_s;

    assign expire_s = (cnt_r == TMO_W'(TMO - 1));
`endif

    // Priority mask: only requesters strictly above the last winner keep precedence.
    always_comb begin
        above_s = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            above_s[k] = (IW'(k) > ptr_r);
        end
    end

    assign masked_s  = req & above_s;
    assign cand_s    = (|masked_s) ? masked_s : req;
    assign win_oh_s  = lsb_onehot(cand_s);
    assign win_idx_s = onehot_to_idx(win_oh_s);
    assign release_s = done | ~req[gnt_idx_r];

    // Next-state, next-grant and pointer update.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        idx_nxt_s   = gnt_idx_r;
        ptr_nxt_s   = ptr_r;
`ifdef QNIGMA_ARB_TIMEOUT_EN
        cnt_nxt_s   = cnt_r;
        tmo_nxt_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt_s = ST_GRANT;
                    gnt_nxt_s   = win_oh_s;
                    idx_nxt_s   = win_idx_s;
                    ptr_nxt_s   = win_idx_s;
`ifdef QNIGMA_ARB_TIMEOUT_EN
                    cnt_nxt_s   = {TMO_W{1'b0}};
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A normal release takes precedence, so done on the expiry edge raises no tmo.
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = {N{1'b0}};
`ifdef QNIGMA_ARB_TIMEOUT_EN
                end else if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                    gnt_nxt_s   = {N{1'b0}};
                    tmo_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + TMO_W'(1);
                end
`else
                end else begin
                    state_nxt_s = ST_GRANT;
                end
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = {N{1'b0}};
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 at top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gnt_r     <= {N{1'b0}};
            gnt_vld_r <= 1'b0;
            gnt_idx_r <= {IW{1'b0}};
            ptr_r     <= IW'(N - 1);
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            gnt_vld_r <= |gnt_nxt_s;
            gnt_idx_r <= idx_nxt_s;
            ptr_r     <= ptr_nxt_s;
        end
    end

`ifdef QNIGMA_ARB_TIMEOUT_EN
    // Watchdog counter and one-cycle forced-release pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {TMO_W{1'b0}};
            tmo_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            tmo_r <= tmo_nxt_s;
        end
    end

    assign tmo = tmo_r;
`else
    assign tmo = 1'b0;
`endif

    assign gnt     = gnt_r;
    assign gnt_vld = gnt_vld_r;
    assign gnt_idx = gnt_idx_r;

endmodule

// File: tb/tb_qnigma_rr_arbiter.sv
// Self-checking bench for qnigma_rr_arbiter (N=4, TMO=8): vector table plus watchdog sequence,
// with expected results queued when stimulus is driven and checked after the clock edge.
module tb_qnigma_rr_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       tmo;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic       tmo;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp;
    int   n_err;

    qnigma_rr_arbiter #(.N(N), .TMO(TMO), .TMO_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .tmo     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [3:0] rq, input logic d,
                                input logic [3:0] g, input logic [1:0] ix);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d; v.gnt = g; v.idx = ix; v.tmo = 1'b0;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (gnt !== e.gnt) begin
                n_err++; $display("FAIL %s gnt: got %b want %b", name, gnt, e.gnt);
            end
            n_cmp++;
            if (gnt_vld !== (|e.gnt)) begin
                n_err++; $display("FAIL %s gnt_vld: got %b want %b", name, gnt_vld, |e.gnt);
            end
            n_cmp++;
            if (gnt_idx !== e.idx) begin
                n_err++; $display("FAIL %s gnt_idx: got %0d want %0d", name, gnt_idx, e.idx);
            end
            n_cmp++;
            if (tmo !== e.tmo) begin
                n_err++; $display("FAIL %s tmo: got %b want %b", name, tmo, e.tmo);
            end
            n_cmp++;
            if (!$onehot0(gnt)) begin
                n_err++; $display("FAIL %s onehot: got %b want at most one bit", name, gnt);
            end
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        rst  = v.rst;
        req  = v.req;
        done = v.done;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic step_t(input logic [3:0] rq, input logic d, input logic [3:0] g,
                          input logic [1:0] ix, input logic t, input string name);
        vec_t v;
        v.rst = 1'b0; v.req = rq; v.done = d; v.gnt = g; v.idx = ix; v.tmo = t;
        step(v, name);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;

        // 1: single requester, done after 3 cycles, same requester regranted after one idle cycle
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2);
        add(1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2);
        add(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2);
        add(1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2);
        // 2: all requesting, fair rotation 0,1,2,3,0
        add(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0);
        add(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0);
        add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0);
        add(1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1);
        add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1);
        add(1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2);
        add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2);
        add(1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3);
        add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3);
        add(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0);
        add(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0);
        // 3: owner drops request, others ignored while held, mask picks above ptr then wraps
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1);
        add(1'b0, 4'b1011, 1'b0, 4'b0010, 2'd1);
        add(1'b0, 4'b1001, 1'b0, 4'b0000, 2'd1);
        add(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3);
        add(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd3);
        add(1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0);
        add(1'b0, 4'b1001, 1'b1, 4'b0000, 2'd0);
        // 4: done and owner request falling together is one release
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0);
        add(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1);
        // 5: reset mid-grant drops grant and restores pointer to N-1
        add(1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1);
        add(1'b1, 4'b0011, 1'b0, 4'b0000, 2'd0);
        add(1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0);
        add(1'b0, 4'b0011, 1'b1, 4'b0000, 2'd0);
        add(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1);
        add(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1);
        add(1'b1, 4'b0110, 1'b0, 4'b0000, 2'd0);
        add(1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1);
        add(1'b0, 4'b0110, 1'b1, 4'b0000, 2'd1);
        // done in IDLE is ignored; index holds while idle
        add(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1);
        add(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2);
        add(1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2);
        add(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // 6: watchdog sequence, requester 0 holds request and never signals done
        begin
            vec_t v;
            v.rst = 1'b1; v.req = 4'b0000; v.done = 1'b0; v.gnt = 4'b0000; v.idx = 2'd0; v.tmo = 1'b0;
            step(v, "wd_rst");
        end
`ifdef QNIGMA_ARB_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            step_t(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, $sformatf("wd_hold%0d", i));
        end
        step_t(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b1, "wd_expire");
        step_t(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "wd_regrant");
        for (int i = 1; i < TMO; i++) begin
            step_t(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, $sformatf("wd_hold2_%0d", i));
        end
        step_t(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, "wd_done_at_expiry");
`else
        for (int i = 0; i < 5 * TMO; i++) begin
            step_t(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, $sformatf("wd_hold%0d", i));
        end
        step_t(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, "wd_done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qnigma_rr_arbiter.md
Name: qnigma_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource, such as a TX datapath or a memory port, between N requesters. Priority selection is one-hot. A rotating mask makes the most recently served requester lowest priority. The grant is held for the whole transaction and released on a done strobe or when the request drops. Sits between the per-requester engines and the shared datapath mux, and drives the mux select directly.

Parameters:
N, 4, number of requesters; legal range 2..32.
TMO, 1024, watchdog limit in clock cycles; used only with the optional feature; must be ≥2.
TMO_W, 16, watchdog counter width; must satisfy 2^TMO_W > TMO.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  reset, synchronous, active-high.
req  input  N  request vector; bit k is requester k; level-sensitive.
done  input  1  end-of-transaction strobe from the current owner; sampled only while gnt_vld=1.
gnt  output  N  registered one-hot grant; all-zero when idle.
gnt_vld  output  1  high while any grant is active; equals OR of gnt.
gnt_idx  output  $clog2(N)  binary index of the granted bit; valid only when gnt_vld=1, holds its last value otherwise.
tmo  output  1  one-cycle pulse on a watchdog forced release; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - gnt=0, gnt_vld=0, gnt_idx=0, tmo=0.
  - State goes to IDLE.
  - Pointer ptr=N-1, so requester 0 has top priority after reset.
  - Watchdog counter is 0.
  - Reset mid-grant drops the grant at that edge; no done is required.
- State IDLE (gnt=0):
  - If req≠0, select a winner and go to GRANT; gnt, gnt_vld and gnt_idx are registered at that edge.
  - Latency: req sampled at edge t gives gnt at edge t (visible in the cycle after t).
  - If req=0, stay in IDLE.
- Winner selection (combinational):
  - Masked vector m = req AND (bits strictly above ptr).
  - If m≠0, the winner is the lowest set bit of m; otherwise it is the lowest set bit of req.
  - Selection is LSB-first one-hot: a bit wins only if all lower bits of the candidate vector are 0.
  - On every grant, ptr is loaded with the winner's index.
- State GRANT:
  - gnt stays constant.
  - Release at an edge when done=1 OR req[gnt_idx]=0 (OR the watchdog expires, if the feature is enabled).
  - Release clears gnt and gnt_vld and returns to IDLE.
  - Exactly one idle cycle (gnt=0) separates consecutive grants, including when the same requester is granted again.
  - Requests other than the owner's are ignored while in GRANT.
  - done while in IDLE is ignored.
  - done and req[owner] falling together count as a single release.
- Fairness: with all N requesters continuously requesting and each granted once, the grant order is 0,1,…,N-1,0,…
- Wrap-around:
  - ptr=N-1 means the mask is empty, so the lowest set bit of req wins.
  - When the only pending request is at or below ptr, it is still granted; the design never starves with a single requester.
- Invariant: gnt is one-hot or zero in every cycle.

Optional Feature:
Macro: QNIGMA_ARB_TIMEOUT_EN.
- Defined:
  - The counter clears on every grant and increments each cycle while in GRANT.
  - When the counter reaches TMO-1 without a release, the next edge forces release: gnt=0, state to IDLE, and tmo=1 for exactly one cycle.
  - ptr still advances past the timed-out requester.
  - If done arrives on the same edge as expiry, it is a normal release and tmo stays 0.
- Not defined: no counter is instantiated, tmo is tied to 0, and grants are held indefinitely.

Test Plan:
1. Reset, then req=4'b0100 held, done pulsed 3 cycles after the grant → gnt=4'b0100 and gnt_idx=2 one edge after req, held 3 cycles, then gnt=0 for 1 cycle, then gnt=4'b0100 again.
2. After reset, req=4'b1111 held, done pulsed 1 cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001, with a one-cycle gap between each.
3. Holder 1 drops req[1] mid-grant while req=4'b1001 is pending → release on that edge; next grant 4'b1000 (mask above ptr=1), then 4'b0001.
4. req=4'b0011 simultaneous with grant 0 active; done and req[0]=0 on the same edge → single release, then gnt=4'b0010; gnt never has 2 bits set.
5. rst pulsed for 1 cycle while gnt=4'b0010 → gnt=0 at that edge; with req=4'b0011 afterwards, the next grant is 4'b0001 (ptr reset to N-1).
6. QNIGMA_ARB_TIMEOUT_EN, TMO=8, req=4'b0001 held, done never asserted → gnt held 8 cycles, then gnt=0 and tmo=1 for 1 cycle, then regranted; without the macro, gnt is held indefinitely and tmo stays 0.
